gcd_ci_driver: RTL and testbench
================================

# gcd_ci_driver

Initiator side of the multi-cycle custom-instruction (CI) handshake used by the GCD accelerator. It accepts operand pairs on a valid/ready command stream, buffers them in a small FIFO, drives clk_en/start/dataa/datab to a CI responder, and waits for done. It then returns each result, or a timeout flag, on a valid/ready response stream. It sits between fabric logic (DMA, test sequencer, CSR bridge) and a gcd_ci-style responder, so hardware can batch GCD work without the Nios II core.

## Interface
- DEPTH, 4: operand FIFO entries; power of 2, ≥2.
- TIMEOUT, 1024: maximum WAIT cycles per operation before abort; ≥2.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  operand pair offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_dataa  in  32  operand A.
- cmd_datab  in  32  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  32  GCD, or 0 on timeout.
- rsp_timeout  out  1  operation aborted by timeout.
- ci_clk_en  out  1  responder clock enable.
- ci_start  out  1  responder start pulse.
- ci_dataa  out  32  responder input A.
- ci_datab  out  32  responder input B.
- ci_result  in  32  responder result.
- ci_done  in  1  responder done; held high while ci_clk_en stays high.
- busy  out  1  state != IDLE or FIFO non-empty.
- pending  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: push on cmd_valid&&cmd_ready; pop on leaving IDLE. Push and pop in the same cycle leaves occupancy unchanged. cmd_ready is low when occupancy is DEPTH; no overwrite.
- States:
  - IDLE: if the FIFO is non-empty, pop the head into the op registers.
    - If either operand is 0, go to RESP with result = A|B and timeout = 0. This is the zero shortcut: gcd(x,0)=x and gcd(0,0)=0. The responder never finishes on zero operands.
    - Otherwise go to ISSUE.
  - ISSUE (1 cycle): ci_clk_en=1, ci_start=1, ci_dataa/ci_datab = op registers; clear the timer; go to WAIT.
  - WAIT: ci_clk_en=1, ci_start=0; the timer increments each cycle.
    - If ci_done=1, capture ci_result with timeout = 0 and go to RESP. ci_done has priority over timeout in the same cycle.
    - Else if timer == TIMEOUT-1, set result = 0 and timeout = 1, and go to RESP.
  - RESP: ci_clk_en=0, so the responder clears done on the next edge. rsp_valid=1. On rsp_ready, go to IDLE.
- ci_dataa/ci_datab hold the last issued operands outside ISSUE. They are don't-care for the responder.
- Timeout abort leaves the responder internally running. The next ISSUE start overrides it, so no extra cleanup is needed.

## Timing
- Reset (asserted at any time, including mid-operation) forces:
  - state IDLE and FIFO empty.
  - rsp_valid=0, rsp_result=0, rsp_timeout=0.
  - ci_clk_en=0, ci_start=0, ci_dataa=0, ci_datab=0.
  - busy=0, pending=0.
  - An in-flight operation is discarded and no response is produced.
- All outputs are flop-driven or decoded from state flops only; there are no combinational paths from inputs to outputs.
- Issue latency for an idle, empty block:
  - Command accepted at edge E0; IDLE sees the entry and moves to ISSUE at E1.
  - ci_start is high for exactly the one cycle between E1 and E2.
- ci_done is sampled from the first WAIT cycle onward. ci_clk_en is low for at least one cycle (RESP) between operations, which guarantees a stale done is cleared before the next start.
- Done capture: ci_done high before edge En moves the block to RESP at En, and rsp_valid is high after En.
- Zero-shortcut latency: rsp_valid is high one cycle after the IDLE pop edge.
- Backpressure: in RESP with rsp_ready=0, rsp_valid/rsp_result/rsp_timeout stay stable. The FIFO keeps accepting commands up to DEPTH.
- Throughput ceiling: one result per (2 + responder cycles + 1) cycles.

## Test plan
- Reset mid-WAIT (A=1000000, B=1) -> all outputs 0 next cycle; no rsp_valid afterwards.
- Single op A=12, B=8 with a gcd_ci responder -> exactly one ci_start pulse; rsp_result=4, rsp_timeout=0; ci_clk_en low during RESP.
- Back-to-back ops (48,18), (17,5), (7,7) pushed with rsp_ready=1 -> results 6, 1, 7 in order. Each start is preceded by at least one ci_clk_en=0 cycle; ci_start is never asserted while ci_done=1.
- Zero operands (0,9) and (0,0) -> results 9 and 0 with no ci_start; (5,0) -> 5.
- Responder done tied low, TIMEOUT=16 -> rsp_timeout=1 and rsp_result=0 after 16 WAIT cycles. The next op (9,6) then returns 3.
- FIFO full: push 6 commands with DEPTH=4 and rsp_ready=0 -> cmd_ready drops after the FIFO fills, with pending=4 and one op held in RESP. After releasing rsp_ready, all accepted ops return in order and none is lost.

Source files
------------

// File: rtl/gcd_ci_driver_if.sv
// Command and response streams of the GCD custom-instruction driver.
// The master is the fabric side; the slave is the driver.
interface gcd_ci_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_dataa;
    logic [31:0] cmd_datab;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_timeout;

    modport master (
        output cmd_valid, cmd_dataa, cmd_datab, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_dataa, cmd_datab, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_timeout
    );
endinterface

// File: rtl/gcd_ci_driver.sv
// Initiator for the multi-cycle GCD custom-instruction handshake.
// Buffers operand pairs, issues them to the responder, returns results.
module gcd_ci_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    gcd_ci_driver_if.slave           bus,
    output logic                     ci_clk_en,
    output logic                     ci_start,
    output logic [31:0]              ci_dataa,
    output logic [31:0]              ci_datab,
    input  logic [31:0]              ci_result,
    input  logic                     ci_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [TW-1:0] timer;
    logic          push;
    logic          pop;
    logic [31:0]   head_a;
    logic [31:0]   head_b;

    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && (count != '0);
    assign {head_a, head_b} = mem[rd_ptr];

    assign bus.cmd_ready = (count != (AW+1)'(DEPTH));
    assign bus.rsp_valid = (state == RESP);
    assign ci_clk_en     = (state == ISSUE) || (state == WAIT);
    assign ci_start      = (state == ISSUE);
    assign busy          = (state != IDLE) || (count != '0);
    assign pending       = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.cmd_dataa, bus.cmd_datab};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            timer           <= '0;
            ci_dataa        <= '0;
            ci_datab        <= '0;
            bus.rsp_result  <= '0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        // A zero operand would never finish in the responder
                        if (head_a == '0 || head_b == '0) begin
                            bus.rsp_result  <= head_a | head_b;
                            bus.rsp_timeout <= 1'b0;
                            state           <= RESP;
                        end else begin
                            ci_dataa <= head_a;
                            ci_datab <= head_b;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (ci_done) begin
                        bus.rsp_result  <= ci_result;
                        bus.rsp_timeout <= 1'b0;
                        state           <= RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        bus.rsp_result  <= '0;
                        bus.rsp_timeout <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_ci_driver.sv
// Randomized bench for gcd_ci_driver with a behavioural GCD responder.
// Expected results come from a queue filled at command acceptance.
module tb_gcd_ci_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ci_clk_en;
    logic        ci_start;
    logic [31:0] ci_dataa;
    logic [31:0] ci_datab;
    logic [31:0] ci_result;
    logic        ci_done;
    logic        busy;
    logic [2:0]  pending;

    gcd_ci_driver_if bus ();

    gcd_ci_driver #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ci_clk_en (ci_clk_en),
        .ci_start  (ci_start),
        .ci_dataa  (ci_dataa),
        .ci_datab  (ci_datab),
        .ci_result (ci_result),
        .ci_done   (ci_done),
        .busy      (busy),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        t;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;
    bit   hang   = 1'b0;

    function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x = a;
        logic [31:0] y = b;
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Responder: result after a random latency, done held until clk_en drops
    int unsigned lat_cnt = 0;
    always @(posedge clk) begin
        if (!ci_clk_en) begin
            ci_done <= 1'b0;
            lat_cnt <= 0;
        end else if (ci_start) begin
            ci_result <= gcd(ci_dataa, ci_datab);
            lat_cnt   <= $urandom_range(6, 1);
            ci_done   <= 1'b0;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1 && !hang) ci_done <= 1'b1;
        end
    end

    int start_cnt = 0;
    int viol      = 0;
    bit en_low    = 1'b1;
    always @(posedge clk) begin
        if (ci_start) begin
            start_cnt <= start_cnt + 1;
            if (ci_done || !en_low) viol <= viol + 1;
        end
        en_low <= ci_start ? 1'b0 : (en_low | !ci_clk_en);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        exp_t e;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_dataa = a;
        bus.cmd_datab = b;
        while (!bus.cmd_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_accept", 32'd0, 32'd1);
        end else begin
            if (a == 0 || b == 0) e = '{a | b, 1'b0};
            else if (hang)        e = '{32'd0, 1'b1};
            else                  e = '{gcd(a, b), 1'b0};
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic collect(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!(bus.rsp_valid && bus.rsp_ready) && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!(bus.rsp_valid && bus.rsp_ready)) begin
                check("rsp_wait", 32'd0, 32'd1);
                return;
            end
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_result", bus.rsp_result, e.r);
                check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.t));
                check("clk_en_in_resp", 32'(ci_clk_en), 32'd0);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_start();
        int t = 0;
        while (!ci_start && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("start_seen", 32'(ci_start), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        int seen;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;

        bus.cmd_valid = 1'b0;
        bus.cmd_dataa = '0;
        bus.cmd_datab = '0;
        bus.rsp_ready = 1'b0;
        #2 reset = 1'b0;
        #3;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_clk_en", 32'(ci_clk_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of a long operation
        hang = 1'b1;
        push(32'd1000000, 32'd1);
        wait_start();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_clk_en", 32'(ci_clk_en), 32'd0);
        check("midrst_start", 32'(ci_start), 32'd0);
        check("midrst_dataa", ci_dataa, 32'd0);
        check("midrst_datab", ci_datab, 32'd0);
        check("midrst_rsp", {bus.rsp_result[30:0], bus.rsp_valid}, 32'd0);
        check("midrst_to", 32'(bus.rsp_timeout), 32'd0);
        check("midrst_busy", {29'd0, pending} | 32'(busy), 32'd0);
        exp_q.delete();
        hang = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("midrst_no_rsp", 32'(seen), 32'd0);

        // Single op and issue latency
        bus.rsp_ready = 1'b0;
        s0 = start_cnt;
        push(32'd12, 32'd8);
        check("issue_lat_idle", 32'(ci_start), 32'd0);
        @(negedge clk);
        check("issue_lat_start", 32'(ci_start), 32'd1);
        @(negedge clk);
        check("issue_lat_wait", {ci_start, ci_clk_en}, 32'd1);
        bus.rsp_ready = 1'b1;
        collect(1);
        check("single_starts", 32'(start_cnt - s0), 32'd1);

        // Back-to-back
        fork
            begin
                push(32'd48, 32'd18);
                push(32'd17, 32'd5);
                push(32'd7, 32'd7);
            end
            collect(3);
        join

        // Zero shortcut
        s0 = start_cnt;
        bus.rsp_ready = 1'b0;
        push(32'd0, 32'd9);
        check("zero_lat_pre", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("zero_lat_post", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        collect(1);
        fork
            begin
                push(32'd0, 32'd0);
                push(32'd5, 32'd0);
            end
            collect(2);
        join
        check("zero_no_start", 32'(start_cnt - s0), 32'd0);

        // Timeout with done held low
        hang = 1'b1;
        push(32'd77, 32'd11);
        wait_start();
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd17);
        collect(1);
        hang = 1'b0;
        push(32'd9, 32'd6);
        collect(1);

        // FIFO full under backpressure
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push($urandom_range(500, 1), $urandom_range(500, 1));
        repeat (20) @(negedge clk);
        check("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("full_pending", 32'(pending), 32'd4);
        check("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        r = bus.rsp_result;
        repeat (5) @(negedge clk);
        check("full_stable", bus.rsp_result, r);
        fork
            push(32'd60, 32'd45);
            begin
                bus.rsp_ready = 1'b1;
                collect(6);
            end
        join

        // Random traffic
        fork
            for (int i = 0; i < 16; i++) begin
                a = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
                b = $urandom_range(100000, 0);
                push(a, b);
            end
            collect(16);
        join

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("start_protocol", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
